// File: rtl/eq_band_mixer.sv
// eq_band_mixer: band-gain mixer and master volume sharing one multiplier across all bands/channels.
// Optional feature macro EQ_MIX_SAT_EN: saturate band sum and volume output (default: two's-complement wrap).
module eq_band_mixer #(
    parameter int unsigned DW        = 16,
    parameter int unsigned NUM_BANDS = 5,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned POT_W     = 12,
    parameter int unsigned AMP_TMO   = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           band_vld,
    input  logic [NUM_CH*NUM_BANDS*DW-1:0] band_data,
    input  logic [NUM_BANDS*POT_W-1:0]     pot,
    input  logic [POT_W-1:0]               pot_vol,
    output logic [NUM_CH*DW-1:0]           out_data,
    output logic                           out_vld,
    output logic                           busy,
    output logic                           ovr,
    output logic                           AMP_ON
);
    localparam int unsigned ACC_W  = DW + 1 + $clog2(NUM_BANDS + 1) + 1;
    localparam int unsigned PROD_W = DW + POT_W + 1;
    localparam int unsigned GAIN_W = DW + 2;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned B_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int unsigned CNT_W  = $clog2(AMP_TMO + 1);

    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [B_W-1:0]   LAST_BAND = B_W'(NUM_BANDS - 1);
    localparam logic [CNT_W-1:0] TMO       = CNT_W'(AMP_TMO);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        VOL
    } state_t;

    // G(x,p) = floor(x * p / 2^(POT_W-1)); result always fits in DW+2 bits
    function automatic logic signed [GAIN_W-1:0] gain(input logic signed [DW-1:0] x,
                                                      input logic [POT_W-1:0]     p);
        logic signed [PROD_W-1:0] xe;
        logic signed [PROD_W-1:0] pe;
        logic signed [PROD_W-1:0] prod;
        xe   = {{(POT_W + 1){x[DW-1]}}, x};
        pe   = {{DW{1'b0}}, 1'b0, p};
        prod = (xe * pe) >>> (POT_W - 1);
        return prod[GAIN_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] ext(input logic signed [GAIN_W-1:0] g);
        return {{(ACC_W - GAIN_W){g[GAIN_W-1]}}, g};
    endfunction

    function automatic logic signed [DW-1:0] fit(input logic signed [ACC_W-1:0] v);
`ifdef EQ_MIX_SAT_EN
        if ((v[ACC_W-1:DW-1] == '0) || (v[ACC_W-1:DW-1] == '1)) begin
            return v[DW-1:0];
        end else if (v[ACC_W-1]) begin
            return {1'b1, {(DW - 1){1'b0}}};
        end else begin
            return {1'b0, {(DW - 1){1'b1}}};
        end
`else
        logic unused_hi;
        unused_hi = ^v[ACC_W-1:DW];
        return v[DW-1:0];
`endif
    endfunction

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [B_W-1:0]          b_q, b_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [DW-1:0]    snap_q [NUM_CH][NUM_BANDS];
    logic signed [DW-1:0]    snap_d [NUM_CH][NUM_BANDS];
    logic [POT_W-1:0]        pot_snap_q [NUM_BANDS];
    logic [POT_W-1:0]        pot_snap_d [NUM_BANDS];
    logic [POT_W-1:0]        vol_snap_q, vol_snap_d;
    logic signed [DW-1:0]    res_q [NUM_CH];
    logic signed [DW-1:0]    res_d [NUM_CH];
    logic [NUM_CH*DW-1:0]    out_data_q, out_data_d;
    logic                    out_vld_q, out_vld_d;
    logic                    ovr_q, ovr_d;
    logic                    amp_on_q, amp_on_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic signed [DW-1:0]     mul_x;
    logic [POT_W-1:0]         mul_p;
    logic signed [GAIN_W-1:0] mul_y;
    logic signed [DW-1:0]     sum_fit;
    logic signed [DW-1:0]     vol_res;
    logic                     accept;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        b_d        = b_q;
        acc_d      = acc_q;
        snap_d     = snap_q;
        pot_snap_d = pot_snap_q;
        vol_snap_d = vol_snap_q;
        res_d      = res_q;
        out_data_d = out_data_q;
        out_vld_d  = 1'b0;

        accept = band_vld && (state_q == IDLE);
        ovr_d  = band_vld && (state_q != IDLE);

        // Single multiplier: band gain during ACC, master volume on the band sum during VOL
        sum_fit = fit(acc_q);
        mul_x   = snap_q[ch_q][b_q];
        mul_p   = pot_snap_q[b_q];
        if (state_q == VOL) begin
            mul_x = sum_fit;
            mul_p = vol_snap_q;
        end
        mul_y   = gain(mul_x, mul_p);
        vol_res = fit(ext(mul_y));

        case (state_q)
            IDLE: begin
                if (band_vld) begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                            snap_d[c][b] = band_data[(c*NUM_BANDS + b)*DW +: DW];
                        end
                    end
                    for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                        pot_snap_d[b] = pot[b*POT_W +: POT_W];
                    end
                    vol_snap_d = pot_vol;
                    ch_d       = '0;
                    b_d        = '0;
                    acc_d      = '0;
                    state_d    = ACC;
                end
            end
            ACC: begin
                acc_d = acc_q + ext(mul_y);
                if (b_q == LAST_BAND) begin
                    state_d = VOL;
                end else begin
                    b_d = b_q + B_W'(1);
                end
            end
            VOL: begin
                if (ch_q == LAST_CH) begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        if (c == NUM_CH - 1) begin
                            out_data_d[c*DW +: DW] = vol_res;
                        end else begin
                            out_data_d[c*DW +: DW] = res_q[c];
                        end
                    end
                    out_vld_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    res_d[ch_q] = vol_res;
                    ch_d        = ch_q + CH_W'(1);
                    b_d         = '0;
                    acc_d       = '0;
                    state_d     = ACC;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            cnt_d = '0;
        end else if (cnt_q != TMO) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // A fresh result re-enables the amplifier even if the idle counter is already saturated
        if (out_vld_d) begin
            amp_on_d = 1'b1;
        end else if (cnt_q == TMO) begin
            amp_on_d = 1'b0;
        end else begin
            amp_on_d = amp_on_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            snap_q     <= '{default: '0};
            pot_snap_q <= '{default: '0};
            vol_snap_q <= '0;
            res_q      <= '{default: '0};
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            ovr_q      <= 1'b0;
            amp_on_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            snap_q     <= snap_d;
            pot_snap_q <= pot_snap_d;
            vol_snap_q <= vol_snap_d;
            res_q      <= res_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            ovr_q      <= ovr_d;
            amp_on_q   <= amp_on_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_data = out_data_q;
    assign out_vld  = out_vld_q;
    assign busy     = (state_q != IDLE);
    assign ovr      = ovr_q;
    assign AMP_ON   = amp_on_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Scoreboard bench for eq_band_mixer: arithmetic reference model, queued expectations, decoupled monitor.
module tb_eq_band_mixer;
    localparam int unsigned DW      = 16;
    localparam int unsigned NB      = 5;
    localparam int unsigned NCH     = 2;
    localparam int unsigned POT_W   = 12;
    localparam int unsigned AMP_TMO = 8;
    localparam int          LAT     = NCH * (NB + 1);
    localparam int          GAP     = LAT + 1;
    localparam longint      UNITY   = 2048;
    localparam longint      MAXV    = 32767;
    localparam longint      MINV    = -32768;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    band_vld = 1'b0;
    logic [NCH*NB*DW-1:0]    band_data = '0;
    logic [NB*POT_W-1:0]     pot = '0;
    logic [POT_W-1:0]        pot_vol = '0;
    logic [NCH*DW-1:0]       out_data;
    logic                    out_vld;
    logic                    busy;
    logic                    ovr;
    logic                    amp_on;

    eq_band_mixer #(
        .DW(DW), .NUM_BANDS(NB), .NUM_CH(NCH), .POT_W(POT_W), .AMP_TMO(AMP_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .band_vld(band_vld), .band_data(band_data),
        .pot(pot), .pot_vol(pot_vol), .out_data(out_data), .out_vld(out_vld),
        .busy(busy), .ovr(ovr), .AMP_ON(amp_on)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NCH*DW-1:0] data;
        int                at;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];
    int   last_acc = -1000;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference model: floor division and modular wrap written as plain integer arithmetic
    function automatic longint gain_m(longint x, longint p);
        longint prod;
        longint q;
        prod = x * p;
        q    = prod / UNITY;
        if (prod < 0 && q * UNITY != prod) q = q - 1;
        return q;
    endfunction

    function automatic longint fit_m(longint v);
`ifdef EQ_MIX_SAT_EN
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
`else
        longint w;
        w = v % 65536;
        if (w < 0) w = w + 65536;
        if (w > MAXV) w = w - 65536;
        return w;
`endif
    endfunction

    function automatic logic [NCH*DW-1:0] mix_m(logic [NCH*NB*DW-1:0] d, logic [NB*POT_W-1:0] p,
                                                logic [POT_W-1:0] v);
        logic [NCH*DW-1:0]    r;
        logic signed [DW-1:0] x;
        longint               acc;
        for (int c = 0; c < NCH; c++) begin
            acc = 0;
            for (int b = 0; b < NB; b++) begin
                x   = d[(c*NB + b)*DW +: DW];
                acc = acc + gain_m(x, p[b*POT_W +: POT_W]);
            end
            r[c*DW +: DW] = DW'(fit_m(gain_m(fit_m(acc), v)));
        end
        return r;
    endfunction

    function automatic logic [NCH*NB*DW-1:0] mk_data(longint l, longint r);
        logic [NCH*NB*DW-1:0] d;
        for (int b = 0; b < NB; b++) begin
            d[b*DW +: DW]        = DW'(l);
            d[(NB + b)*DW +: DW] = DW'(r);
        end
        return d;
    endfunction

    function automatic logic [NB*POT_W-1:0] mk_pots(int v);
        logic [NB*POT_W-1:0] p;
        for (int b = 0; b < NB; b++) p[b*POT_W +: POT_W] = POT_W'(v);
        return p;
    endfunction

    // Called just after a rising edge; band_vld is sampled on the next edge
    task automatic issue(input logic [NCH*NB*DW-1:0] d, input logic [NB*POT_W-1:0] p,
                         input logic [POT_W-1:0] v);
        int e;
        exp_t x;
        e = cyc + 1;
        band_data = d;
        pot       = p;
        pot_vol   = v;
        band_vld  = 1'b1;
        if (e >= last_acc + GAP) begin
            x.data = mix_m(d, p, v);
            x.at   = e + LAT;
            exp_q.push_back(x);
            last_acc = e;
        end else begin
            ovr_q.push_back(e);
        end
        @(posedge clk);
        #1;
        band_vld = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(output logic [NCH*DW-1:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            if (out_vld) begin
                d  = out_data;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("out_timeout", out_vld, 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a result or an overrun
    initial begin
        exp_t e;
        int   o;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                chk("out_missing_at", cyc, e.at);
            end
            while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
                o = ovr_q.pop_front();
                chk("ovr_missing_at", cyc, o);
            end
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    chk("out_vld_unexpected", out_vld, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc, e.at);
                    for (int c = 0; c < NCH; c++)
                        chk($sformatf("out_ch%0d", c), $signed(out_data[c*DW +: DW]),
                            $signed(e.data[c*DW +: DW]));
                end
            end
            if (ovr) begin
                if (ovr_q.size() == 0) begin
                    chk("ovr_unexpected", ovr, 0);
                end else begin
                    o = ovr_q.pop_front();
                    chk("ovr_cycle", cyc, o);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*DW-1:0]    d;
        logic [NCH*NB*DW-1:0] rd;
        logic [NB*POT_W-1:0]  rp;
        bit                   ok;
        int                   a;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_amp_on", amp_on, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unity gains, then amplifier enable/timeout
        issue(mk_data(1000, -1000), mk_pots(2048), 12'd2048);
        chk("busy_after_accept", busy, 1);
        wait_out(d, ok);
        if (ok) begin
            chk("unity_L", $signed(d[0 +: DW]), 5000);
            chk("unity_R", $signed(d[DW +: DW]), -5000);
            chk("amp_rise", amp_on, 1);
            chk("busy_low_at_vld", busy, 0);
        end
        @(negedge clk);
        chk("amp_drop", amp_on, 0);
        repeat (10) @(negedge clk);
        chk("amp_stays_low", amp_on, 0);
        @(posedge clk);
        #1;

        // Single band gain with floor rounding on the negative channel
        rp = '0;
        rp[2*POT_W +: POT_W] = 12'd1024;
        issue(mk_data(1000, -1001), rp, 12'd2048);
        wait_out(d, ok);
        if (ok) begin
            chk("band_L", $signed(d[0 +: DW]), 500);
            chk("band_R", $signed(d[DW +: DW]), -501);
        end
        @(posedge clk);
        #1;

        // Band-sum overflow
        issue(mk_data(16000, -16000), mk_pots(2048), 12'd2048);
        wait_out(d, ok);
        if (ok) begin
`ifdef EQ_MIX_SAT_EN
            chk("ovf_L", $signed(d[0 +: DW]), 32767);
            chk("ovf_R", $signed(d[DW +: DW]), -32768);
`else
            chk("ovf_L", $signed(d[0 +: DW]), 14464);
            chk("ovf_R", $signed(d[DW +: DW]), -14464);
`endif
        end
        @(posedge clk);
        #1;

        // Overrun 3 cycles in, then a request coincident with out_vld
        issue(mk_data(300, -700), mk_pots(2048), 12'd1024);
        a = last_acc;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        issue(mk_data(-9999, 8888), mk_pots(4095), 12'd4095);
        wait_until(a + LAT);
        issue(mk_data(-1234, 4321), mk_pots(1500), 12'd3000);
        chk("accept_on_out_vld", last_acc, a + GAP);
        wait_until(last_acc + LAT + 2);

        // Reset at edge 5 of a mix
        wait_until(last_acc + GAP - 1);
        issue(mk_data(777, -555), mk_pots(2048), 12'd2048);
        a = last_acc;
        wait_until(a + 4);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_acc = -1000;
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_vld", out_vld, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovr", ovr, 0);
        chk("midrst_amp_on", amp_on, 0);
        repeat (3 * LAT) begin
            @(posedge clk);
            #1;
        end
        issue(mk_data(2500, -3500), mk_pots(1024), 12'd4095);
        wait_until(last_acc + LAT + 2);

        // Randomized traffic, including requests that arrive while busy
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 15)) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < NCH * NB; i++) rd[i*DW +: DW] = DW'($urandom);
            for (int b = 0; b < NB; b++)
                rp[b*POT_W +: POT_W] = (t % 4 == 0) ? 12'd2048 : POT_W'($urandom_range(0, 4095));
            issue(rd, rp, POT_W'($urandom_range(0, 4095)));
        end

        wait_until(last_acc + LAT + 3);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("ovr_queue_drained", ovr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eq_band_mixer.md
# eq_band_mixer

Parametrised, time-multiplexed band-gain mixer and volume stage for the equalizer digital core. Takes one snapshot of NUM_BANDS filtered samples per channel, applies a per-band pot gain with a single shared multiplier, sums the bands, applies master volume, and presents all channels with a one-cycle valid strobe. It replaces the parallel per-band scaler/adder fabric between the FIR bank and the codec output, and adds overrun detection and a timeout-based amplifier enable.

## Interface
- DW, 16, signed sample width (in and out)
- NUM_BANDS, 5, bands per channel (≥1)
- NUM_CH, 2, audio channels (≥1); channel 0 = left
- POT_W, 12, unsigned pot width
- AMP_TMO, 4096, idle cycles without band_vld before AMP_ON drops (≥2)

- clk  in  1  single clock, all flops rising-edge
- rst_n  in  1  synchronous, active-low reset
- band_vld  in  1  one-cycle strobe: band_data/pot/pot_vol valid
- band_data  in  NUM_CH*NUM_BANDS*DW  signed; slice [(c*NUM_BANDS+b)*DW +: DW] = channel c, band b
- pot  in  NUM_BANDS*POT_W  unsigned band gains; slice b shared by all channels
- pot_vol  in  POT_W  unsigned master volume
- out_data  out  NUM_CH*DW  signed mixed result; slice c*DW +: DW
- out_vld  out  1  one-cycle strobe, out_data updated
- busy  out  1  mix in progress, band_vld not accepted
- ovr  out  1  one-cycle pulse: band_vld dropped
- AMP_ON  out  1  amplifier enable

## Operation
- Gain op G(x,p) = (x * {1'b0,p}) >>> (POT_W-1), arithmetic (floor); p = 2^(POT_W-1) is unity, max ≈ 2×.
- States: IDLE, ACC, VOL.
- IDLE: band_vld=1 → snapshot band_data, pot, pot_vol into registers; ch=0, b=0, acc=0; → ACC.
- ACC: acc += G(snap[ch][b], pot_snap[b]); b++; after b=NUM_BANDS-1 → VOL.
- VOL: sum = fit(acc); res[ch] = fit(G(sum, vol_snap)); if ch<NUM_CH-1: ch++, b=0, acc=0, → ACC; else out_data ← all res, out_vld=1, → IDLE.
- Accumulator width DW+1+$clog2(NUM_BANDS+1)+1; no internal overflow.
- fit(): DW-bit saturation or wrap per Configuration.
- busy = (state != IDLE).
- band_vld while busy: ignored, ovr=1 for that cycle, snapshot untouched.
- band_vld in the cycle out_vld=1: state is IDLE, accepted normally.
- AMP_ON: counter cleared on every accepted band_vld; AMP_ON set on out_vld; counter saturates at AMP_TMO; AMP_ON cleared when counter reaches AMP_TMO.

## Timing
- Reset: state=IDLE, out_data=0, out_vld=0, busy=0, ovr=0, AMP_ON=0, counter=0, acc=0. Reset mid-mix aborts; no out_vld produced.
- Latency: out_vld high in the cycle following NUM_CH*(NUM_BANDS+1) clock edges after the edge sampling band_vld (defaults: 12 edges).
- busy high from the edge after acceptance through the VOL edge of the last channel; low while out_vld is high.
- Max accepted rate: one band_vld per NUM_CH*(NUM_BANDS+1)+1 cycles.
- out_data holds between strobes; changes only on the out_vld edge.
- ovr is combinational-free: registered, asserted the cycle after the dropped band_vld.

## Configuration
- EQ_MIX_SAT_EN defined: fit() clamps to [-2^(DW-1), 2^(DW-1)-1] at both the band-sum and the volume output.
- Undefined: fit() keeps low DW bits (two's-complement wrap), bit-compatible with the legacy adder path.

## Test plan
- Unity: all bands L=1000, R=-1000, all pots and pot_vol=2048 → out_vld exactly 12 edges after capture, L=5000, R=-5000.
- Band gains: only pot[2]=1024 (others 0), band2 L=1000, R=-1001, vol 2048 → L=500, R=-501 (floor).
- Overflow: all bands L=16000, unity pots → EQ_MIX_SAT_EN: L=32767; without: L=14464.
- Overrun: second band_vld 3 cycles after first → ovr pulse once, single out_vld, result from first snapshot; band_vld coincident with out_vld → accepted, second out_vld 12 edges later.
- AMP_ON: AMP_TMO=8; one mix → AMP_ON rises with out_vld; no further band_vld → AMP_ON low 8 cycles after acceptance counter start, counter stays saturated.
- Reset at edge 5 of a mix → all outputs 0, no out_vld; next band_vld mixes correctly.
